// File: rtl/uc_pkg.sv
// Shared definitions for the micro-controller pipeline control block:
// FSM state encoding, default timing parameters and the Moore output decode.
// Optional interrupt support is enabled with the UC_PIPE_CTRL_IRQ_EN macro.
package uc_pkg;

  localparam int JMP_HOLD_CYCLES_DEF = 2;
  localparam int MEM_WAIT_MAX_DEF    = 3;

`ifdef UC_PIPE_CTRL_IRQ_EN
  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_JMP_HOLD  = 3'd1,
    ST_JMP_FLUSH = 3'd2,
    ST_MEM_WAIT  = 3'd3,
    ST_IRQ_ENTRY = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_JMP_HOLD  = 3'd1,
    ST_JMP_FLUSH = 3'd2,
    ST_MEM_WAIT  = 3'd3
  } state_e;
`endif

  typedef struct packed {
    logic pc_en;
    logic stall;
    logic flush;
    logic pc_sel_jmp;
    logic busy;
  } ctrl_out_t;

  // Values held on the control outputs while reset is asserted.
  localparam ctrl_out_t CTRL_RESET = '{pc_en: 1'b0, stall: 1'b1, flush: 1'b0,
                                       pc_sel_jmp: 1'b0, busy: 1'b0};

  // Counter width: enough bits for the larger of the two limits, plus one.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

  // Moore decode of the pipeline control outputs from a state.
  function automatic ctrl_out_t decode_state(input state_e s);
    ctrl_out_t o;
    o = '{pc_en: 1'b1, stall: 1'b0, flush: 1'b0, pc_sel_jmp: 1'b0, busy: 1'b1};
    case (s)
      ST_RUN:       o.busy = 1'b0;
      ST_JMP_HOLD:  begin o.pc_en = 1'b0; o.stall = 1'b1; end
      ST_JMP_FLUSH: begin o.flush = 1'b1; o.pc_sel_jmp = 1'b1; end
      ST_MEM_WAIT:  begin o.pc_en = 1'b0; o.stall = 1'b1; end
`ifdef UC_PIPE_CTRL_IRQ_EN
      ST_IRQ_ENTRY: o.flush = 1'b1;
`endif
      default:      o = CTRL_RESET;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/uc_sat_counter.sv
// Saturating up/down counter with synchronous load and a terminal-value flag.
// Load has priority over counting; the count never wraps in either direction.
module uc_sat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  input  logic         i_inc,
  input  logic [W-1:0] i_term,
  output logic         o_term
);

  logic [W-1:0] r_count;

  // Count register: load, then saturating decrement or increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_term = (r_count == i_term);

endmodule

// File: rtl/uc_pipe_ctrl.sv
// Pipeline control FSM: conditional-jump hold/flush, data-memory wait with
// timeout and, when UC_PIPE_CTRL_IRQ_EN is defined, interrupt entry.
// Outputs are registered from the next-state decode so they track the state.
module uc_pipe_ctrl
  import uc_pkg::*;
#(
  parameter int JMP_HOLD_CYCLES = JMP_HOLD_CYCLES_DEF,
  parameter int MEM_WAIT_MAX    = MEM_WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic cndjmp_req,
  input  logic jmp_taken,
  input  logic mem_req,
  input  logic mem_ready,
`ifdef UC_PIPE_CTRL_IRQ_EN
  input  logic irq,
  output logic irq_ack,
`endif
  output logic pc_en,
  output logic stall,
  output logic flush,
  output logic pc_sel_jmp,
  output logic mem_timeout,
  output logic busy
);

  localparam int CW = cnt_width(JMP_HOLD_CYCLES, MEM_WAIT_MAX);

  state_e    r_state;
  state_e    w_next;
  ctrl_out_t r_out;
  logic      r_mem_timeout;
  logic      w_timeout;
  logic      w_hold_load;
  logic      w_hold_dec;
  logic      w_hold_last;
  logic      w_wait_load;
  logic      w_wait_inc;
  logic      w_wait_last;
  logic      w_irq_req;

`ifdef UC_PIPE_CTRL_IRQ_EN
  logic r_irq_pend;
  logic r_irq_ack;
  assign w_irq_req = irq | r_irq_pend;
  assign irq_ack   = r_irq_ack;
`else
  assign w_irq_req = 1'b0;
`endif

  // Hold counter: loaded on jump entry, last hold cycle when it reads 1.
  uc_sat_counter #(.W(CW)) u_hold_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_hold_load),
    .i_load_val (CW'(JMP_HOLD_CYCLES)),
    .i_dec      (w_hold_dec),
    .i_inc      (1'b0),
    .i_term     (CW'(1)),
    .o_term     (w_hold_last)
  );

  // Wait counter: cleared on wait entry; the cycle at MAX-1 is the last one
  // allowed, its increment would reach MEM_WAIT_MAX.
  uc_sat_counter #(.W(CW)) u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_wait_load),
    .i_load_val ('0),
    .i_dec      (1'b0),
    .i_inc      (w_wait_inc),
    .i_term     (CW'(MEM_WAIT_MAX - 1)),
    .o_term     (w_wait_last)
  );

  // Next-state and counter-control decode with cndjmp > mem > irq priority.
  always_comb begin
    w_next      = r_state;
    w_timeout   = 1'b0;
    w_hold_load = 1'b0;
    w_hold_dec  = 1'b0;
    w_wait_load = 1'b0;
    w_wait_inc  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (cndjmp_req) begin
          w_next      = ST_JMP_HOLD;
          w_hold_load = 1'b1;
        end else if (mem_req) begin
          if (mem_ready) begin
            w_next = ST_RUN;
          end else begin
            w_next      = ST_MEM_WAIT;
            w_wait_load = 1'b1;
          end
        end else if (w_irq_req) begin
`ifdef UC_PIPE_CTRL_IRQ_EN
          w_next = ST_IRQ_ENTRY;
`else
          w_next = ST_RUN;
`endif
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_JMP_HOLD: begin
        w_hold_dec = 1'b1;
        if (w_hold_last) begin
          w_next = jmp_taken ? ST_JMP_FLUSH : ST_RUN;
        end else begin
          w_next = ST_JMP_HOLD;
        end
      end
      ST_JMP_FLUSH: w_next = ST_RUN;
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          w_next = ST_RUN;
        end else if (w_wait_last) begin
          w_next     = ST_RUN;
          w_timeout  = 1'b1;
          w_wait_inc = 1'b1;
        end else begin
          w_next     = ST_MEM_WAIT;
          w_wait_inc = 1'b1;
        end
      end
`ifdef UC_PIPE_CTRL_IRQ_EN
      ST_IRQ_ENTRY: w_next = ST_RUN;
`endif
      default: w_next = ST_RUN;
    endcase
  end

  // State and registered outputs; reset forces RUN with stalled outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_out         <= CTRL_RESET;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_out         <= decode_state(w_next);
      r_mem_timeout <= w_timeout;
    end
  end

`ifdef UC_PIPE_CTRL_IRQ_EN
  // Interrupt bookkeeping: remember a request until IRQ_ENTRY is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_pend <= 1'b0;
      r_irq_ack  <= 1'b0;
    end else begin
      r_irq_pend <= w_irq_req && (w_next != ST_IRQ_ENTRY);
      r_irq_ack  <= (w_next == ST_IRQ_ENTRY);
    end
  end
`endif

  assign pc_en       = r_out.pc_en;
  assign stall       = r_out.stall;
  assign flush       = r_out.flush;
  assign pc_sel_jmp  = r_out.pc_sel_jmp;
  assign busy        = r_out.busy;
  assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_uc_pipe_ctrl.sv
// Directed self-checking bench for uc_pipe_ctrl (default build, default
// parameters). Observed vector is {pc_en, stall, flush, pc_sel_jmp, busy,
// mem_timeout}, sampled 1 time unit after each rising clock edge.
module tb_uc_pipe_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic cndjmp_req, jmp_taken, mem_req, mem_ready;
  logic pc_en, stall, flush, pc_sel_jmp, mem_timeout, busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] V_RST   = 6'b010000;
  localparam logic [5:0] V_RUN   = 6'b100000;
  localparam logic [5:0] V_HOLD  = 6'b010010;
  localparam logic [5:0] V_FLUSH = 6'b101110;
  localparam logic [5:0] V_WAIT  = 6'b010010;
  localparam logic [5:0] V_TOUT  = 6'b100001;

  uc_pipe_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cndjmp_req  (cndjmp_req),
    .jmp_taken   (jmp_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .stall       (stall),
    .flush       (flush),
    .pc_sel_jmp  (pc_sel_jmp),
    .mem_timeout (mem_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {pc_en, stall, flush, pc_sel_jmp, busy, mem_timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cndjmp_req = 1'b0; jmp_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #2;
    checks++;
    if (obs() !== V_RST) begin failures++; $display("FAIL reset_async got=%b exp=%b", obs(), V_RST); end
    tick();
    checks++;
    if (obs() !== V_RST) begin failures++; $display("FAIL reset_held got=%b exp=%b", obs(), V_RST); end
    reset = 1'b0;
    tick();
    checks++;
    if (obs() !== V_RUN) begin failures++; $display("FAIL reset_first_run got=%b exp=%b", obs(), V_RUN); end
  endtask

  task automatic test_jmp_not_taken();
    logic [5:0] exp_v [0:3] = '{V_HOLD, V_HOLD, V_RUN, V_RUN};
    cndjmp_req = 1'b1; jmp_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cndjmp_req = 1'b0;
      checks++;
      if (obs() !== exp_v[i]) begin failures++; $display("FAIL jmp_not_taken[%0d] got=%b exp=%b", i, obs(), exp_v[i]); end
    end
  endtask

  task automatic test_jmp_taken();
    logic [5:0] exp_v [0:3] = '{V_HOLD, V_HOLD, V_FLUSH, V_RUN};
    cndjmp_req = 1'b1; jmp_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cndjmp_req = 1'b0;
      checks++;
      if (obs() !== exp_v[i]) begin failures++; $display("FAIL jmp_taken[%0d] got=%b exp=%b", i, obs(), exp_v[i]); end
    end
    jmp_taken = 1'b0;
  endtask

  task automatic test_mem_wait2();
    logic [5:0] exp_v [0:3] = '{V_WAIT, V_WAIT, V_RUN, V_RUN};
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_req = 1'b0;
      checks++;
      if (obs() !== exp_v[i]) begin failures++; $display("FAIL mem_wait2[%0d] got=%b exp=%b", i, obs(), exp_v[i]); end
      mem_ready = (i == 1);
    end
  endtask

  task automatic test_mem_timeout();
    logic [5:0] exp_v [0:4] = '{V_WAIT, V_WAIT, V_WAIT, V_TOUT, V_RUN};
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      mem_req = 1'b0;
      checks++;
      if (obs() !== exp_v[i]) begin failures++; $display("FAIL mem_timeout[%0d] got=%b exp=%b", i, obs(), exp_v[i]); end
    end
  endtask

  task automatic test_timeout_ready_race();
    logic [5:0] exp_v [0:4] = '{V_WAIT, V_WAIT, V_WAIT, V_RUN, V_RUN};
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      mem_req = 1'b0;
      checks++;
      if (obs() !== exp_v[i]) begin failures++; $display("FAIL timeout_race[%0d] got=%b exp=%b", i, obs(), exp_v[i]); end
      mem_ready = (i == 2);
    end
  endtask

  task automatic test_zero_wait();
    mem_req = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      mem_req = 1'b0; mem_ready = 1'b0;
      checks++;
      if (obs() !== V_RUN) begin failures++; $display("FAIL zero_wait[%0d] got=%b exp=%b", i, obs(), V_RUN); end
    end
  endtask

  task automatic test_jmp_and_mem();
    logic [5:0] exp_v [0:4] = '{V_HOLD, V_HOLD, V_RUN, V_RUN, V_RUN};
    cndjmp_req = 1'b1; mem_req = 1'b1; mem_ready = 1'b0; jmp_taken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cndjmp_req = 1'b0; mem_req = 1'b0;
      checks++;
      if (obs() !== exp_v[i]) begin failures++; $display("FAIL jmp_and_mem[%0d] got=%b exp=%b", i, obs(), exp_v[i]); end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] exp_v [0:3] = '{V_HOLD, V_HOLD, V_RUN, V_RUN};
    cndjmp_req = 1'b1; jmp_taken = 1'b0;
    tick();
    cndjmp_req = 1'b0;
    checks++;
    if (obs() !== V_HOLD) begin failures++; $display("FAIL rst_hold_entry got=%b exp=%b", obs(), V_HOLD); end
    reset = 1'b1;
    #1;
    checks++;
    if (obs() !== V_RST) begin failures++; $display("FAIL rst_hold_async got=%b exp=%b", obs(), V_RST); end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (obs() !== V_RUN) begin failures++; $display("FAIL rst_hold_run got=%b exp=%b", obs(), V_RUN); end
    cndjmp_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cndjmp_req = 1'b0;
      checks++;
      if (obs() !== exp_v[i]) begin failures++; $display("FAIL rst_hold_restart[%0d] got=%b exp=%b", i, obs(), exp_v[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_jmp_not_taken();
    test_jmp_taken();
    test_mem_wait2();
    test_mem_timeout();
    test_timeout_ready_race();
    test_zero_wait();
    test_jmp_and_mem();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
